// File: rtl/counter_pkg.sv
// Shared encodings for the cascadable counter: counting modes and one-shot FSM states.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_step.sv
// Combinational step unit: value after one enabled step, terminal detect and landing detect.
module counter_step
  import counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic [COUNTER_WIDTH-1:0] COUNT,
  input  logic                     DIR,
  input  logic [1:0]               MODE,
  input  logic [COUNTER_WIDTH-1:0] MAX,
  output logic [COUNTER_WIDTH-1:0] NEXT,
  output logic                     TERMINAL,
  output logic                     LANDS
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] stepped;

  always_comb begin
    NEXT     = COUNT;
    LANDS    = 1'b0;
    // ">=" on the way up lets a count stranded above a lowered MAX recover.
    TERMINAL = DIR ? (COUNT >= MAX) : (COUNT == '0);
    stepped  = DIR ? (COUNT + ONE) : (COUNT - ONE);
    if (MODE == MODE_SAT || MODE == MODE_ONESHOT) begin
      NEXT  = TERMINAL ? COUNT : stepped;
      LANDS = !TERMINAL && (DIR ? (stepped >= MAX) : (stepped == '0));
    end else begin
      NEXT  = TERMINAL ? (DIR ? '0 : MAX) : stepped;
    end
  end

endmodule

// File: rtl/cascadable_counter.sv
// Runtime-modulus up/down counter with load, wrap/saturate/one-shot modes, compare
// match and a combinational carry for chaining instances.
module cascadable_counter
  import counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE_IN,
  input  logic                     DIR_IN,
  input  logic [1:0]               MODE_IN,
  input  logic [COUNTER_WIDTH-1:0] MAX_IN,
  input  logic                     LOAD_IN,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
  input  logic                     START_IN,
  input  logic [COUNTER_WIDTH-1:0] CMP_IN,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic                     TRIG_OUT,
  output logic                     CARRY_OUT,
  output logic                     CMP_OUT,
  output logic                     BUSY_OUT,
  output logic [1:0]               FSM_STATE
);

  state_t                   state, state_d;
  logic [COUNTER_WIDTH-1:0] count_d, step_next;
  logic                     trig_d, cmp_d, terminal, lands, oneshot, wrap_mode;

  counter_step #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_step (
    .COUNT    (COUNT),
    .DIR      (DIR_IN),
    .MODE     (MODE_IN),
    .MAX      (MAX_IN),
    .NEXT     (step_next),
    .TERMINAL (terminal),
    .LANDS    (lands)
  );

  assign oneshot   = (MODE_IN == MODE_ONESHOT);
  assign wrap_mode = !oneshot && (MODE_IN != MODE_SAT);
  assign CARRY_OUT = ENABLE_IN & terminal & wrap_mode;
  assign BUSY_OUT  = (state == ST_RUN);
  assign FSM_STATE = state;

  always_comb begin
    count_d = COUNT;
    trig_d  = 1'b0;
    state_d = state;
    if (LOAD_IN) begin
      count_d = (LOAD_VALUE > MAX_IN) ? MAX_IN : LOAD_VALUE;
    end else if (START_IN) begin
      if (oneshot) begin
        count_d = DIR_IN ? '0 : MAX_IN;
        state_d = ST_RUN;
      end
    end else if (ENABLE_IN) begin
      if (oneshot) begin
        // A run that reaches terminal by any route (including a load) ends here.
        if (state == ST_RUN) begin
          count_d = step_next;
          if (terminal || lands) begin
            state_d = ST_DONE;
            trig_d  = 1'b1;
          end
        end
      end else begin
        count_d = step_next;
        trig_d  = (MODE_IN == MODE_SAT) ? lands : terminal;
      end
    end
    if (!oneshot) state_d = ST_IDLE;
    cmp_d = (count_d == CMP_IN) && (LOAD_IN || (count_d != COUNT));
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      COUNT    <= '0;
      TRIG_OUT <= 1'b0;
      CMP_OUT  <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      COUNT    <= count_d;
      TRIG_OUT <= trig_d;
      CMP_OUT  <= cmp_d;
      state    <= state_d;
    end
  end

endmodule

// File: tb/tb_cascadable_counter.sv
// Directed and random checks of cascadable_counter (W=4) plus a two-digit BCD cascade.
module tb_cascadable_counter;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, dir, load, start;
  logic [1:0]   mode;
  logic [W-1:0] max_v, load_v, cmp_v;
  logic [W-1:0] count;
  logic         trig, carry, cmp_o, busy;
  logic [1:0]   fsm;

  logic         cas_rst_n, cas_en;
  logic [W-1:0] lo_count, hi_count;
  logic         lo_trig, lo_carry, lo_cmp, lo_busy, hi_trig, hi_carry, hi_cmp, hi_busy;
  logic [1:0]   lo_fsm, hi_fsm;

  int checks = 0;
  int errors = 0;

  // {count, trig, cmp, busy, state}
  logic [8:0]   exp_q[$];
  logic [W-1:0] m_count;
  int           m_state;
  logic         m_carry;
  logic         m_valid = 1'b0;

  cascadable_counter #(.COUNTER_WIDTH(W)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE_IN(en), .DIR_IN(dir), .MODE_IN(mode),
    .MAX_IN(max_v), .LOAD_IN(load), .LOAD_VALUE(load_v), .START_IN(start), .CMP_IN(cmp_v),
    .COUNT(count), .TRIG_OUT(trig), .CARRY_OUT(carry), .CMP_OUT(cmp_o), .BUSY_OUT(busy),
    .FSM_STATE(fsm)
  );

  cascadable_counter #(.COUNTER_WIDTH(W)) u_lo (
    .CLK(clk), .RESET_N(cas_rst_n), .ENABLE_IN(cas_en), .DIR_IN(1'b1), .MODE_IN(2'b00),
    .MAX_IN(4'd9), .LOAD_IN(1'b0), .LOAD_VALUE(4'd0), .START_IN(1'b0), .CMP_IN(4'd0),
    .COUNT(lo_count), .TRIG_OUT(lo_trig), .CARRY_OUT(lo_carry), .CMP_OUT(lo_cmp),
    .BUSY_OUT(lo_busy), .FSM_STATE(lo_fsm)
  );

  cascadable_counter #(.COUNTER_WIDTH(W)) u_hi (
    .CLK(clk), .RESET_N(cas_rst_n), .ENABLE_IN(lo_carry), .DIR_IN(1'b1), .MODE_IN(2'b00),
    .MAX_IN(4'd9), .LOAD_IN(1'b0), .LOAD_VALUE(4'd0), .START_IN(1'b0), .CMP_IN(4'd0),
    .COUNT(hi_count), .TRIG_OUT(hi_trig), .CARRY_OUT(hi_carry), .CMP_OUT(hi_cmp),
    .BUSY_OUT(hi_busy), .FSM_STATE(hi_fsm)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic d, input logic [1:0] m, input logic [3:0] mx,
                       input logic l, input logic [3:0] lv, input logic s, input logic [3:0] c);
    en = e; dir = d; mode = m; max_v = mx; load = l; load_v = lv; start = s; cmp_v = c;
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_edge();
    logic [W-1:0] nc;
    logic         t, c, term, wrapm, osm;
    int           ns;
    nc    = m_count;
    t     = 1'b0;
    ns    = m_state;
    osm   = (mode == 2'b10);
    wrapm = (mode == 2'b00) || (mode == 2'b11);
    term  = dir ? (m_count >= max_v) : (m_count == 0);
    m_carry = en && term && wrapm;
    if (!rst_n) begin
      nc = 0; ns = 0; c = 1'b0;
    end else begin
      if (load) begin
        nc = (load_v > max_v) ? max_v : load_v;
      end else if (start) begin
        if (osm) begin nc = dir ? 4'd0 : max_v; ns = 1; end
      end else if (en) begin
        if (wrapm) begin
          if (term) begin nc = dir ? 4'd0 : max_v; t = 1'b1; end
          else nc = dir ? m_count + 4'd1 : m_count - 4'd1;
        end else if (mode == 2'b01) begin
          if (!term) begin
            nc = dir ? m_count + 4'd1 : m_count - 4'd1;
            t  = dir ? (nc >= max_v) : (nc == 0);
          end
        end else if (m_state == 1) begin
          if (term) begin ns = 2; t = 1'b1; end
          else begin
            nc = dir ? m_count + 4'd1 : m_count - 4'd1;
            if (dir ? (nc >= max_v) : (nc == 0)) begin ns = 2; t = 1'b1; end
          end
        end
      end
      if (!osm) ns = 0;
      c = (nc == cmp_v) && (load || (nc != m_count));
    end
    exp_q.push_back({nc, t, c, (ns == 1), 2'(ns)});
    m_count = nc;
    m_state = ns;
  endtask

  task automatic cycle(input string tag);
    logic [8:0] e;
    logic       check_carry;
    check_carry = m_valid;
    model_edge();
    #1;
    if (check_carry) chk({tag, " carry"}, 8'(carry), 8'(m_carry));
    @(posedge clk);
    #1;
    m_valid = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed count %0d", tag, count);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " count"}, 8'(count), 8'(e[8:5]));
      chk({tag, " trig"},  8'(trig),  8'(e[4]));
      chk({tag, " cmp"},   8'(cmp_o), 8'(e[3]));
      chk({tag, " busy"},  8'(busy),  8'(e[2]));
      chk({tag, " fsm"},   8'(fsm),   8'(e[1:0]));
    end
  endtask

  initial begin
    m_count   = '0;
    m_state   = 0;
    cas_rst_n = 1'b0;
    cas_en    = 1'b0;
    rst_n     = 1'b0;
    drive(1, 1, 2'b00, 9, 0, 0, 0, 15);
    @(posedge clk); #1;
    cycle("reset");
    cycle("reset2");
    chk("reset count const", 8'(count), 8'd0);
    chk("reset fsm const", 8'(fsm), 8'd0);
    rst_n = 1'b1;

    // Wrap up, MAX=9, 11 steps.
    for (int i = 0; i < 11; i++) cycle("t1 wrap up");
    chk("t1 final count", 8'(count), 8'd1);

    // Wrap down from 0, then lowered MAX recovery going up.
    drive(0, 0, 2'b00, 5, 1, 0, 0, 15); cycle("t2 load0");
    drive(1, 0, 2'b00, 5, 0, 0, 0, 15);
    cycle("t2 down first");
    chk("t2 down trig const", 8'(trig), 8'd1);
    chk("t2 down count const", 8'(count), 8'd5);
    cycle("t2 down"); cycle("t2 down");
    drive(0, 1, 2'b00, 9, 1, 7, 0, 15); cycle("t2 load7");
    drive(1, 1, 2'b00, 3, 0, 0, 0, 15); cycle("t2 lowered max");
    chk("t2 recover count const", 8'(count), 8'd0);
    chk("t2 recover trig const", 8'(trig), 8'd1);

    // Saturate up, MAX=3.
    drive(0, 1, 2'b01, 3, 1, 0, 0, 15); cycle("t3 load0");
    drive(1, 1, 2'b01, 3, 0, 0, 0, 15);
    for (int i = 0; i < 6; i++) cycle("t3 sat");
    chk("t3 held count const", 8'(count), 8'd3);

    // One-shot down, MAX=4.
    drive(0, 0, 2'b10, 4, 0, 0, 1, 15); cycle("t4 start");
    drive(1, 0, 2'b10, 4, 0, 0, 0, 15);
    for (int i = 0; i < 6; i++) cycle("t4 run");
    chk("t4 done fsm const", 8'(fsm), 8'd2);
    chk("t4 done busy const", 8'(busy), 8'd0);
    drive(0, 0, 2'b10, 4, 0, 0, 1, 15); cycle("t4 rearm");
    chk("t4 rearm count const", 8'(count), 8'd4);

    // Load clamps to MAX and hits compare.
    drive(1, 1, 2'b00, 9, 1, 12, 0, 9); cycle("t5 load clamp");
    chk("t5 cmp const", 8'(cmp_o), 8'd1);
    chk("t5 trig const", 8'(trig), 8'd0);

    // Reset mid-run.
    drive(0, 1, 2'b10, 9, 0, 0, 1, 15); cycle("t6 start");
    drive(1, 1, 2'b10, 9, 0, 0, 0, 2);
    cycle("t6 run"); cycle("t6 run");
    rst_n = 1'b0;
    cycle("t6 reset");
    chk("t6 reset busy const", 8'(busy), 8'd0);
    rst_n = 1'b1;

    // Random mixed traffic.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
      cycle("random");
    end

    // Two-digit BCD cascade: 00..99 then back to 00 with upper TRIG.
    @(posedge clk); #1;
    cas_rst_n = 1'b1;
    chk("cascade reset lo", 8'(lo_count), 8'd0);
    chk("cascade reset hi", 8'(hi_count), 8'd0);
    cas_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      chk("cascade lo", 8'(lo_count), 8'((k % 100) % 10));
      chk("cascade hi", 8'(hi_count), 8'((k % 100) / 10));
      chk("cascade hi trig", 8'(hi_trig), 8'(k == 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
